spi_slave_regs: RTL and testbench

//  SPI responder (mode 0, MSB first, 8-bit frames) with the same 2-bit addr/rden/wren register

---
 rtl/spi_pkg.sv | 26 ++
 rtl/sync_fifo.sv | 58 +++++
 rtl/spi_slave_regs.sv | 213 +++++++++++++++++++++
 tb/tb_spi_slave_regs.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI responder: register map, STATUS bit
// positions, FIFO sizing defaults and the frame FSM state encoding.
package spi_pkg;

  localparam int SPI_FDEPTH = 4;
  localparam int SPI_FAW    = 2;

  localparam logic [1:0] ADDR_TXDATA = 2'd0;
  localparam logic [1:0] ADDR_RXDATA = 2'd1;
  localparam logic [1:0] ADDR_STATUS = 2'd2;

  localparam int STAT_TXFULL  = 0;
  localparam int STAT_DATARDY = 1;
  localparam int STAT_RXOVF   = 2;
  localparam int STAT_TXUNDER = 3;
  localparam int STAT_TXOVF   = 4;
  localparam int STAT_TXEMPTY = 5;
  localparam int STAT_SSACT   = 6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2
  } spi_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with a combinational head.
// Handshake: push/pop are single-cycle strobes. A pop is taken only when
// the FIFO is not empty; a push is taken when the FIFO is not full, or when
// it is full but a pop is taken in the same cycle (count then unchanged).
// Untaken strobes are silently ignored; callers flag overflow themselves.
module sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == DEPTH_C);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  // Storage array; contents only matter between push and pop.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointer and occupancy tracking; pointers wrap naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/spi_slave_regs.sv
// SPI mode-0 responder with an 8-bit, 2-bit-address register interface.
// MOSI bytes land in an RX FIFO, MISO bytes come from a TX FIFO. All SPI
// pins are synchronised into clk; the bus side is fully synchronous.
module spi_slave_regs
  import spi_pkg::*;
#(
  parameter int FDEPTH = SPI_FDEPTH,
  parameter int FAW    = SPI_FAW
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] din,
  output logic [7:0] dout,
  input  logic       wren,
  input  logic       rden,
  input  logic [1:0] addr,
  input  logic       sclk,
  input  logic       ss_n,
  input  logic       mosi,
  output logic       miso,
  output logic       miso_oe,
  output logic [1:0] state_dbg
);

  spi_state_t state, state_next;

  logic       sclk_s1, sclk_s2, sclk_s3;
  logic       mosi_s1, mosi_s2;
  logic       ss_s1, ss_s2, ss_d;
  logic [1:0] ss_vld;
  logic       sclk_rise, sclk_fall, ss_fall, ss_rise;

  logic [7:0] tx_sr;
  logic [6:0] rx_sr;
  logic [2:0] bitcnt;
  logic       rxovf, txunder, txovf;

  logic       load_tx, rx_push, shift_in, shift_out;
  logic [7:0] rx_byte, tx_head, status;

  logic       tx_push, tx_full, tx_empty;
  logic [7:0] tx_rdata;
  logic       rx_pop, rx_full, rx_empty;
  logic [7:0] rx_rdata;
  logic       clr_wr;

  // Pin synchronisers. ss_n flops reset to "deselected" so miso_oe is low
  // in reset; ss_d only follows ss_s2 once the chain holds real pin samples,
  // so a select that is already low when reset ends is never seen as a fall.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sclk_s1 <= 1'b0;
      sclk_s2 <= 1'b0;
      sclk_s3 <= 1'b0;
      mosi_s1 <= 1'b0;
      mosi_s2 <= 1'b0;
      ss_s1   <= 1'b1;
      ss_s2   <= 1'b1;
      ss_vld  <= 2'b00;
      ss_d    <= 1'b0;
    end else begin
      sclk_s1 <= sclk;
      sclk_s2 <= sclk_s1;
      sclk_s3 <= sclk_s2;
      mosi_s1 <= mosi;
      mosi_s2 <= mosi_s1;
      ss_s1   <= ss_n;
      ss_s2   <= ss_s1;
      ss_vld  <= {ss_vld[0], 1'b1};
      ss_d    <= ss_vld[1] ? ss_s2 : 1'b0;
    end
  end

  assign sclk_rise = sclk_s2 && !sclk_s3;
  assign sclk_fall = !sclk_s2 && sclk_s3;
  assign ss_fall   = ss_d && !ss_s2;
  assign ss_rise   = !ss_d && ss_s2;
  assign miso_oe   = !ss_s2;
  assign miso      = tx_sr[7];
  assign state_dbg = state;

  assign rx_byte = {rx_sr, mosi_s2};
  assign tx_head = tx_empty ? 8'h00 : tx_rdata;

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Next state and per-cycle datapath strobes; deselect wins over everything.
  // The falling edge right after a (re)load is the trailing edge of the
  // previous bit, so it must not shift the freshly loaded byte.
  always_comb begin
    state_next = state;
    load_tx    = 1'b0;
    rx_push    = 1'b0;
    shift_in   = 1'b0;
    shift_out  = 1'b0;
    if (ss_rise) begin
      state_next = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (ss_fall) state_next = ST_LOAD;
        ST_LOAD: begin
          load_tx    = 1'b1;
          state_next = ST_SHIFT;
        end
        ST_SHIFT: begin
          if (sclk_rise) begin
            shift_in = 1'b1;
            if (bitcnt == 3'd7) begin
              rx_push = 1'b1;
              load_tx = 1'b1;
            end
          end else if (sclk_fall && bitcnt != 3'd0) begin
            shift_out = 1'b1;
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  // Shift registers and bit counter; miso is the top of tx_sr.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_sr  <= 8'h00;
      rx_sr  <= 7'h00;
      bitcnt <= 3'd0;
    end else if (ss_rise) begin
      tx_sr  <= 8'h00;
      rx_sr  <= 7'h00;
      bitcnt <= 3'd0;
    end else begin
      if (load_tx)        tx_sr <= tx_head;
      else if (shift_out) tx_sr <= {tx_sr[6:0], 1'b0};
      if (state == ST_LOAD) bitcnt <= 3'd0;
      if (shift_in) begin
        rx_sr  <= rx_byte[6:0];
        bitcnt <= bitcnt + 3'd1;
      end
    end
  end

  assign tx_push = wren && (addr == ADDR_TXDATA);
  assign rx_pop  = rden && (addr == ADDR_RXDATA);
  assign clr_wr  = wren && (addr == ADDR_STATUS);

  // Sticky error flags: write-1-to-clear, but a new event in the same
  // cycle as the clear keeps the flag set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rxovf   <= 1'b0;
      txunder <= 1'b0;
      txovf   <= 1'b0;
    end else begin
      if (clr_wr && din[STAT_RXOVF])   rxovf   <= 1'b0;
      if (clr_wr && din[STAT_TXUNDER]) txunder <= 1'b0;
      if (clr_wr && din[STAT_TXOVF])   txovf   <= 1'b0;
      if (rx_push && rx_full && !(rx_pop && !rx_empty)) rxovf   <= 1'b1;
      if (load_tx && tx_empty)                          txunder <= 1'b1;
      if (tx_push && tx_full && !(load_tx && !tx_empty)) txovf  <= 1'b1;
    end
  end

  // STATUS register assembly.
  always_comb begin
    status               = 8'h00;
    status[STAT_TXFULL]  = tx_full;
    status[STAT_DATARDY] = !rx_empty;
    status[STAT_RXOVF]   = rxovf;
    status[STAT_TXUNDER] = txunder;
    status[STAT_TXOVF]   = txovf;
    status[STAT_TXEMPTY] = tx_empty;
    status[STAT_SSACT]   = !ss_s2;
  end

  // Bus read mux; TXDATA is write-only and address 3 is reserved.
  always_comb begin
    dout = 8'h00;
    if (rden) begin
      case (addr)
        ADDR_RXDATA: dout = rx_empty ? 8'h00 : rx_rdata;
        ADDR_STATUS: dout = status;
        default:     dout = 8'h00;
      endcase
    end
  end

  sync_fifo #(.W(8), .DEPTH(FDEPTH), .AW(FAW)) u_tx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (tx_push),
    .pop   (load_tx),
    .wdata (din),
    .rdata (tx_rdata),
    .full  (tx_full),
    .empty (tx_empty)
  );

  sync_fifo #(.W(8), .DEPTH(FDEPTH), .AW(FAW)) u_rx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (rx_push),
    .pop   (rx_pop),
    .wdata (rx_byte),
    .rdata (rx_rdata),
    .full  (rx_full),
    .empty (rx_empty)
  );

endmodule

// File: tb/tb_spi_slave_regs.sv
// Bench for spi_slave_regs: a behavioural SPI master (sclk = clk/8, drives
// mosi on sclk fall, samples miso on sclk rise) plus a byte-level model of
// the TX/RX queues and sticky flags.
module tb_spi_slave_regs;
  import spi_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] din;
  logic [7:0] dout;
  logic       wren;
  logic       rden;
  logic [1:0] addr;
  logic       sclk;
  logic       ss_n;
  logic       mosi;
  logic       miso;
  logic       miso_oe;
  logic [1:0] state_dbg;

  int checks   = 0;
  int failures = 0;

  // Reference model state.
  logic [7:0] tx_q[$];
  logic [7:0] rx_q[$];
  logic       m_rxovf, m_txunder, m_txovf, m_ss_act;
  logic [7:0] m_cur;

  spi_slave_regs dut (
    .clk       (clk),
    .reset     (reset),
    .din       (din),
    .dout      (dout),
    .wren      (wren),
    .rden      (rden),
    .addr      (addr),
    .sclk      (sclk),
    .ss_n      (ss_n),
    .mosi      (mosi),
    .miso      (miso),
    .miso_oe   (miso_oe),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  task automatic clk_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [7:0] m_status();
    return {1'b0, m_ss_act, (tx_q.size() == 0), m_txovf, m_txunder, m_rxovf,
            (rx_q.size() != 0), (tx_q.size() == SPI_FDEPTH)};
  endfunction

  function automatic void m_reset();
    tx_q.delete();
    rx_q.delete();
    m_rxovf   = 1'b0;
    m_txunder = 1'b0;
    m_txovf   = 1'b0;
    m_ss_act  = 1'b0;
    m_cur     = 8'h00;
  endfunction

  // Byte the responder will send next: TX head, or zero with an underrun.
  function automatic void m_load();
    if (tx_q.size() > 0) m_cur = tx_q.pop_front();
    else begin
      m_cur     = 8'h00;
      m_txunder = 1'b1;
    end
  endfunction

  function automatic void m_rx_push(input logic [7:0] b);
    if (rx_q.size() < SPI_FDEPTH) rx_q.push_back(b);
    else m_rxovf = 1'b1;
  endfunction

  task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    addr = a;
    din  = d;
    wren = 1'b1;
    @(negedge clk);
    wren = 1'b0;
    if (a == ADDR_TXDATA) begin
      if (tx_q.size() < SPI_FDEPTH) tx_q.push_back(d);
      else m_txovf = 1'b1;
    end else if (a == ADDR_STATUS) begin
      if (d[2]) m_rxovf   = 1'b0;
      if (d[3]) m_txunder = 1'b0;
      if (d[4]) m_txovf   = 1'b0;
    end
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
    @(negedge clk);
    addr = a;
    rden = 1'b1;
    #2;
    d = dout;
    @(negedge clk);
    rden = 1'b0;
  endtask

  task automatic check_status(input string tag);
    logic [7:0] d;
    bus_read(ADDR_STATUS, d);
    check8(tag, d, m_status());
  endtask

  task automatic read_rx_check(input string tag);
    logic [7:0] d;
    logic [7:0] exp;
    bus_read(ADDR_RXDATA, d);
    exp = (rx_q.size() > 0) ? rx_q.pop_front() : 8'h00;
    check8(tag, d, exp);
  endtask

  task automatic spi_select();
    @(negedge clk);
    ss_n     = 1'b0;
    m_ss_act = 1'b1;
    m_load();
    clk_n(4);
  endtask

  task automatic spi_deselect();
    clk_n(4);
    ss_n = 1'b1;
    clk_n(6);
    m_ss_act = 1'b0;
  endtask

  // Shift nbits (MSB first) of b; checks the miso bits seen so far against
  // the byte the model expects. A full byte lands in RX and reloads TX.
  task automatic spi_byte(input logic [7:0] b, input int nbits, input string tag);
    logic [7:0] got;
    logic [7:0] mask;
    got  = 8'h00;
    mask = 8'hFF;
    mask = mask << (8 - nbits);
    for (int i = 7; i > 7 - nbits; i--) begin
      mosi = b[i];
      clk_n(4);
      sclk   = 1'b1;
      got[i] = miso;
      clk_n(4);
      sclk = 1'b0;
    end
    check8(tag, got & mask, m_cur & mask);
    if (nbits == 8) begin
      m_rx_push(b);
      m_load();
    end
  endtask

  initial begin
    logic [7:0] rb;
    int nw, nf, nr;

    m_reset();
    reset = 1'b1;
    din   = 8'h00;
    wren  = 1'b0;
    rden  = 1'b0;
    addr  = 2'd0;
    sclk  = 1'b0;
    ss_n  = 1'b1;
    mosi  = 1'b0;
    clk_n(3);
    rden = 1'b1;
    addr = ADDR_STATUS;
    #1;
    check8("reset_status", dout, 8'h20);
    rden = 1'b0;
    check8("reset_miso", {7'd0, miso}, 8'h00);
    check8("reset_miso_oe", {7'd0, miso_oe}, 8'h00);
    @(negedge clk);
    reset = 1'b0;
    clk_n(5);
    check8("idle_after_reset", {6'd0, state_dbg}, {6'd0, ST_IDLE});
    read_rx_check("rx_empty_reads_zero");

    // 1: single frame
    bus_write(ADDR_TXDATA, 8'hA5);
    check_status("t1_status_queued");
    spi_select();
    check_status("t1_status_ss_active");
    check8("t1_miso_oe", {7'd0, miso_oe}, 8'h01);
    spi_byte(8'h3C, 8, "t1_miso_byte");
    spi_deselect();
    check_status("t1_status_datardy");
    read_rx_check("t1_rx_byte");
    check_status("t1_status_drained");

    // 2: back-to-back frames under one select
    bus_write(ADDR_TXDATA, 8'h11);
    bus_write(ADDR_TXDATA, 8'h22);
    spi_select();
    spi_byte(8'h55, 8, "t2_miso_0");
    spi_byte(8'h62, 8, "t2_miso_1");
    spi_deselect();
    read_rx_check("t2_rx_0");
    read_rx_check("t2_rx_1");

    // 3: underrun and its clear
    bus_write(ADDR_STATUS, 8'h1C);
    spi_select();
    spi_byte(8'h38, 8, "t3_miso_zero");
    spi_deselect();
    check_status("t3_status_txunder");
    bus_write(ADDR_STATUS, 8'h08);
    check_status("t3_status_cleared");
    read_rx_check("t3_rx");

    // 4: RX overflow and TX overflow
    spi_select();
    for (int i = 0; i <= SPI_FDEPTH; i++) spi_byte(8'h80 + 8'(i), 8, "t4_miso");
    spi_deselect();
    check_status("t4_status_rxovf");
    for (int i = 0; i < SPI_FDEPTH; i++) read_rx_check("t4_rx_order");
    read_rx_check("t4_rx_empty");
    for (int i = 0; i < 5; i++) bus_write(ADDR_TXDATA, 8'hD0 + 8'(i));
    check_status("t4_status_txfull_txovf");

    // 5: aborted partial frame
    spi_select();
    spi_byte(8'h5A, 5, "t5_partial_miso");
    spi_deselect();
    check_status("t5_status_after_abort");
    spi_select();
    spi_byte(8'hF3, 8, "t5_miso");
    spi_deselect();
    read_rx_check("t5_rx");
    bus_write(ADDR_STATUS, 8'h1C);
    check_status("t5_status_cleared");

    // 6: reset mid-frame
    spi_select();
    spi_byte(8'h9A, 3, "t6_partial_miso");
    @(negedge clk);
    reset = 1'b1;
    #2;
    rden = 1'b1;
    addr = ADDR_STATUS;
    #1;
    check8("t6_status_in_reset", dout, 8'h20);
    rden = 1'b0;
    check8("t6_miso", {7'd0, miso}, 8'h00);
    check8("t6_miso_oe", {7'd0, miso_oe}, 8'h00);
    m_reset();
    clk_n(3);
    reset = 1'b0;
    clk_n(10);
    m_ss_act = 1'b1;
    check8("t6_idle_with_ss_low", {6'd0, state_dbg}, {6'd0, ST_IDLE});
    check_status("t6_status_ss_low");
    ss_n = 1'b1;
    clk_n(6);
    m_ss_act = 1'b0;
    bus_write(ADDR_TXDATA, 8'hC3);
    spi_select();
    spi_byte(8'h2C, 8, "t6_miso_after_reset");
    spi_deselect();
    check_status("t6_status_after_frame");
    read_rx_check("t6_rx");

    // Randomised traffic against the model.
    for (int it = 0; it < 10; it++) begin
      nw = $urandom_range(0, 5);
      for (int k = 0; k < nw; k++) bus_write(ADDR_TXDATA, 8'($urandom_range(0, 255)));
      nf = $urandom_range(1, 3);
      spi_select();
      for (int k = 0; k < nf; k++) spi_byte(8'($urandom_range(0, 255)), 8, "rnd_miso");
      if ($urandom_range(0, 3) == 0) spi_byte(8'($urandom_range(0, 255)), $urandom_range(1, 7), "rnd_partial");
      spi_deselect();
      check_status("rnd_status");
      nr = $urandom_range(0, 5);
      for (int k = 0; k < nr; k++) read_rx_check("rnd_rx");
      if ($urandom_range(0, 1) == 1) bus_write(ADDR_STATUS, 8'($urandom_range(0, 255)));
      check_status("rnd_status_end");
    end
    bus_read(2'd3, rb);
    check8("reserved_reads_zero", rb, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
